lookup_port_arbiter: RTL

Round-robin arbiter and sequencer that shares a single clamped-index table lookup pipeline among `NUM_REQ` requesters. It owns the 4-entry × `DATA_WIDTH` lookup table and its configuration write port. It accepts at most one lookup per cycle and computes `table[min(sel+1, 3)]` over a fixed two-cycle pipeline. Each result is returned tagged with the originating requester's ID. The block sits between the request-issuing clients and the downstream consumer of lookup results.

---
 rtl/lookup_port_arbiter.sv | 106 ++++++++++
 1 files changed

// File: rtl/lookup_port_arbiter.sv
// Round-robin front end sharing one two-stage clamped table lookup among NUM_REQ requesters.
// Results come back tagged with the requester index, in grant order, with no backpressure.
module lookup_port_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_we,
    input  logic [1:0]              cfg_addr,
    input  logic [DATA_WIDTH-1:0]   cfg_wdata,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [2*NUM_REQ-1:0]    req_sel,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    rsp_valid,
    output logic [ID_WIDTH-1:0]     rsp_id,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic                    busy
);

    localparam logic [ID_WIDTH:0] NREQ = (ID_WIDTH+1)'(NUM_REQ);

    function automatic logic [1:0] clamp_idx(input logic [1:0] sel);
        logic [2:0] idx3;
        idx3 = {1'b0, sel} + 3'd1;
        return (idx3 > 3'd3) ? 2'd3 : idx3[1:0];
    endfunction

    // Modular add for requester indices; NUM_REQ need not be a power of two.
    function automatic logic [ID_WIDTH-1:0] wrap_add(input logic [ID_WIDTH-1:0] base,
                                                     input logic [ID_WIDTH:0]   off);
        logic [ID_WIDTH:0] s;
        s = {1'b0, base} + off;
        if (s >= NREQ) s = s - NREQ;
        return s[ID_WIDTH-1:0];
    endfunction

    logic [DATA_WIDTH-1:0] tbl_q [0:3];
    logic [ID_WIDTH-1:0]   ptr_q, ptr_d;

    logic                  vld_p0_q;
    logic [1:0]            sel_p0_q;
    logic [ID_WIDTH-1:0]   id_p0_q;
    logic                  vld_p1_q;
    logic [ID_WIDTH-1:0]   id_p1_q;
    logic [DATA_WIDTH-1:0] data_p1_q;

    logic [NUM_REQ-1:0]    grant;
    logic [ID_WIDTH-1:0]   gnt_id;
    logic [ID_WIDTH-1:0]   cand;
    logic                  found;
    logic                  xfer;
    logic [1:0]            sel_gnt;

    always_comb begin
        grant  = '0;
        gnt_id = '0;
        cand   = '0;
        found  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = wrap_add(ptr_q, (ID_WIDTH+1)'(k));
            if (!found && req_valid[cand]) begin
                grant[cand] = 1'b1;
                gnt_id      = cand;
                found       = 1'b1;
            end
        end
        if (!rst_n) grant = '0;
    end

    assign req_ready = grant;
    assign xfer      = |grant;
    assign sel_gnt   = 2'(req_sel >> {gnt_id, 1'b0});
    assign ptr_d     = xfer ? wrap_add(gnt_id, (ID_WIDTH+1)'(1)) : ptr_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q     <= '0;
            for (int i = 0; i < 4; i++) tbl_q[i] <= '0;
            vld_p0_q  <= 1'b0;
            sel_p0_q  <= '0;
            id_p0_q   <= '0;
            vld_p1_q  <= 1'b0;
            id_p1_q   <= '0;
            data_p1_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (cfg_we) tbl_q[cfg_addr] <= cfg_wdata;
            // stage 0: accept the granted request
            vld_p0_q  <= xfer;
            sel_p0_q  <= sel_gnt;
            id_p0_q   <= gnt_id;
            // stage 1: table read sees pre-write contents on a same-edge collision
            vld_p1_q  <= vld_p0_q;
            id_p1_q   <= id_p0_q;
            data_p1_q <= tbl_q[clamp_idx(sel_p0_q)];
        end
    end

    assign rsp_valid = vld_p1_q;
    assign rsp_id    = id_p1_q;
    assign rsp_data  = data_p1_q;
    assign busy      = vld_p0_q | vld_p1_q;

endmodule
